// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one W-bit Alu between two requesters, with a registered response channel.
// Optional grant counters are enabled by defining ALU_ARB_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a request; one ready asserted when any valid is present
// EXEC  | latched operands drive the Alu; result registered into rsp_*
// RESP  | response held until rsp_ready
module alu_arbiter #(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [W-1:0]     req0_a,
   input  logic [W-1:0]     req0_b,
   input  logic [3:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [W-1:0]     req1_a,
   input  logic [W-1:0]     req1_b,
   input  logic [3:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [W-1:0]     rsp_res,
   output logic             rsp_zero,
   output logic             busy,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic           prio;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic [3:0]     op_code;
   logic           op_id;
   logic           gnt_any;
   logic           gnt_id;
   logic [W-1:0]   alu_res;

   // Ready is gated by rst_n so nothing is accepted on a reset edge.
   always_comb begin
      gnt_id     = (req0_valid & req1_valid) ? prio : req1_valid;
      gnt_any    = rst_n & (state == IDLE) & (req0_valid | req1_valid);
      req0_ready = gnt_any & ~gnt_id;
      req1_ready = gnt_any & gnt_id;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_any) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_comb begin
      alu_res = '0;
      case (op_code)
         4'b0010: alu_res = op_a + op_b;
         4'b0110: alu_res = op_a - op_b;
         4'b0111: alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
         4'b0000: alu_res = op_a & op_b;
         4'b0001: alu_res = op_a | op_b;
         // 1 unless A is strictly positive as a signed value
         4'b0100: alu_res = {{(W-1){1'b0}}, (op_a[W-1] | (op_a == '0))};
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         prio      <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         op_code   <= '0;
         op_id     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_res   <= '0;
         rsp_zero  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (gnt_any) begin
            op_a    <= gnt_id ? req1_a  : req0_a;
            op_b    <= gnt_id ? req1_b  : req0_b;
            op_code <= gnt_id ? req1_op : req0_op;
            op_id   <= gnt_id;
            prio    <= ~gnt_id;
         end
         if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            rsp_res   <= alu_res;
            rsp_zero  <= (alu_res == '0);
         end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (req0_ready && cnt0 != {CNT_W{1'b1}})
            cnt0 <= cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
         if (req1_ready && cnt1 != {CNT_W{1'b1}})
            cnt1 <= cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign gnt_cnt0 = cnt0;
   assign gnt_cnt1 = cnt1;
`else
   assign gnt_cnt0 = '0;
   assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases with literal expectations, then random traffic
// checked every cycle against a transaction-level model.
module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
   logic [31:0] rsp_res;
   logic [15:0] gnt_cnt0, gnt_cnt1;

   int total = 0;
   int bad   = 0;

   alu_arbiter #(.W(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_res(rsp_res), .rsp_zero(rsp_zero), .busy(busy),
      .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return (a < b) ? 32'd1 : 32'd0;
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0100: return ($signed(a) > 0) ? 32'd0 : 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   // Transaction model: one op in flight, its response visible one edge after the grant.
   bit          chk_en = 0;
   bit          m_out = 0, m_vis = 0, m_prio = 0, m_id = 0, m_zero = 0;
   bit          m_acc0 = 0, m_acc1 = 0;
   logic [31:0] m_res = '0;
   int          m_c0 = 0, m_c1 = 0;

   always @(posedge clk) begin
      bit gid;
      m_acc0 = 0;
      m_acc1 = 0;
      if (!rst_n) begin
         m_out = 0; m_vis = 0; m_prio = 0; m_c0 = 0; m_c1 = 0;
         chk_en = 1;
      end else if (!m_out) begin
         if (req0_valid || req1_valid) begin
            gid = (req0_valid && req1_valid) ? m_prio : req1_valid;
            m_res  = gid ? alu_model(req1_op, req1_a, req1_b) : alu_model(req0_op, req0_a, req0_b);
            m_zero = (m_res == 0);
            m_id   = gid;
            m_out  = 1;
            m_prio = !gid;
            if (gid) begin m_acc1 = 1; if (m_c1 < 65535) m_c1++; end
            else     begin m_acc0 = 1; if (m_c0 < 65535) m_c0++; end
         end
      end else if (!m_vis) begin
         m_vis = 1;
      end else if (rsp_ready) begin
         m_out = 0;
         m_vis = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit any, gid;
         any = rst_n && !m_out && (req0_valid || req1_valid);
         gid = (req0_valid && req1_valid) ? m_prio : req1_valid;
         chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, any && !gid});
         chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, any && gid});
         chk("m_busy", {31'd0, busy}, {31'd0, m_out});
         chk("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_vis});
         if (m_vis) begin
            chk("m_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
            chk("m_rsp_res", rsp_res, m_res);
            chk("m_rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
         end
`ifdef ALU_ARB_STATS_EN
         chk("m_gnt_cnt0", {16'd0, gnt_cnt0}, m_c0);
         chk("m_gnt_cnt1", {16'd0, gnt_cnt1}, m_c1);
`else
         chk("m_gnt_cnt0", {16'd0, gnt_cnt0}, 32'd0);
         chk("m_gnt_cnt1", {16'd0, gnt_cnt1}, 32'd0);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Issue one op from an idle DUT with rsp_ready=1 and check the literal result.
   task automatic do_single(input bit id, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] er, input bit ez, input string nm);
      if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
      else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
      @(negedge clk);
      chk({nm, "_ready"}, {31'd0, id ? req1_ready : req0_ready}, 32'd1);
      tick();
      req0_valid = 0;
      req1_valid = 0;
      @(negedge clk);
      chk({nm, "_exec_nv"}, {31'd0, rsp_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk({nm, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, "_res"}, rsp_res, er);
      chk({nm, "_zero"}, {31'd0, rsp_zero}, {31'd0, ez});
      chk({nm, "_id"}, {31'd0, rsp_id}, {31'd0, id});
      tick();
   endtask

   function automatic logic [3:0] rand_op();
      logic [3:0] ops [8];
      ops = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001, 4'b1111, 4'b0100, 4'b0010};
      if ($urandom_range(0, 7) == 0) return 4'($urandom);
      return ops[$urandom_range(0, 7)];
   endfunction

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 5))
         0: return 32'hFFFF_FFFF;
         1: return 32'($urandom_range(0, 3));
         2: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_n = 0; rsp_ready = 1;
      req0_valid = 1; req0_a = 32'd7; req0_b = 32'd7; req0_op = 4'b0110;
      req1_valid = 1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 4'b0111;
      tick();
      tick();
      @(negedge clk);
      chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_res", rsp_res, 32'd0);
      tick();
      rst_n = 1;

      // contention: alternation starting at requester 0
      @(negedge clk);
      chk("ct_first_r0", {31'd0, req0_ready}, 32'd1);
      chk("ct_first_r1", {31'd0, req1_ready}, 32'd0);
      tick();
      @(negedge clk);
      chk("ct_exec_busy", {31'd0, busy}, 32'd1);
      chk("ct_exec_nv", {31'd0, rsp_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("ct_rsp0_res", rsp_res, 32'd0);
      chk("ct_rsp0_zero", {31'd0, rsp_zero}, 32'd1);
      chk("ct_rsp0_id", {31'd0, rsp_id}, 32'd0);
      tick();
      @(negedge clk);
      chk("ct_second_r1", {31'd0, req1_ready}, 32'd1);
      chk("ct_second_r0", {31'd0, req0_ready}, 32'd0);
      tick();
      tick();
      @(negedge clk);
      chk("ct_rsp1_res", rsp_res, 32'd1);
      chk("ct_rsp1_zero", {31'd0, rsp_zero}, 32'd0);
      chk("ct_rsp1_id", {31'd0, rsp_id}, 32'd1);
      tick();
      @(negedge clk);
      chk("ct_third_r0", {31'd0, req0_ready}, 32'd1);
      tick();
      req0_valid = 0; req1_valid = 0;
      tick();
      tick();

      do_single(0, 32'd5, 32'd3, 4'b0010, 32'd8, 0, "add");
      do_single(1, 32'hFFFF_FFFF, 32'd0, 4'b0100, 32'd1, 0, "pos_neg");
      do_single(0, 32'd1, 32'd0, 4'b0100, 32'd0, 1, "pos_one");
      do_single(1, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1, "add_wrap");
      do_single(0, 32'd9, 32'd4, 4'b1010, 32'd0, 1, "undef_op");
      do_single(1, 32'd3, 32'd5, 4'b0110, 32'hFFFF_FFFE, 0, "sub_wrap");

      // backpressure with a request waiting behind it
      rsp_ready = 0;
      req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'b0001;
      @(negedge clk);
      chk("bp_grant", {31'd0, req1_ready}, 32'd1);
      tick();
      req1_valid = 0;
      req0_valid = 1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 4'b0000;
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_hold_res", rsp_res, 32'hFF);
         chk("bp_hold_id", {31'd0, rsp_id}, 32'd1);
         chk("bp_no_ready", {31'd0, req0_ready}, 32'd0);
         tick();
      end
      rsp_ready = 1;
      tick();
      @(negedge clk);
      chk("bp_next_grant", {31'd0, req0_ready}, 32'd1);
      tick();
      req0_valid = 0;
      tick();
      tick();

      // reset while in EXEC drops the operation
      req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0010;
      tick();
      req0_valid = 0;
      rst_n = 0;
      @(negedge clk);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      tick();
      rst_n = 1;
      @(negedge clk);
      chk("mid_nv", {31'd0, rsp_valid}, 32'd0);
      chk("mid_idle", {31'd0, busy}, 32'd0);
`ifdef ALU_ARB_STATS_EN
      chk("mid_cnt0", {16'd0, gnt_cnt0}, 32'd0);
`endif
      tick();
      @(negedge clk);
      chk("mid_nv2", {31'd0, rsp_valid}, 32'd0);
      tick();

      // random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         if (m_acc0 || !req0_valid) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_a = rand_val(); req0_b = rand_val(); req0_op = rand_op();
         end
         if (m_acc1 || !req1_valid) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_a = rand_val(); req1_b = rand_val(); req1_op = rand_op();
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         rst_n = ($urandom_range(0, 599) != 0);
         tick();
      end
      rst_n = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
      for (int c = 0; c < 4; c++) tick();
      @(negedge clk);
      chk("end_idle", {31'd0, busy}, 32'd0);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
